dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipeline's data port. It accepts the single-cycle requests that the EX stage drives (address, write data, write enable, byte count) and performs the access against an internal word-organised array with byte-lane writes. It returns read data and a response code. Accesses that cross a word boundary are either split into two beats, with a busy indication, or rejected with an error code.

## Interface
- `DEPTH`, 1024: number of `WORD_W`-bit words in the array; word index = `addr[ADDR_W-1:2]`.
- `ALLOW_SPLIT`, 1: 1 = boundary-crossing accesses run in two beats; 0 = rejected with `MEM_CODE_MISALIGNED`.
- `clk` in 1: single clock, rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `i_mem_req_addr` in `ADDR_W` (32): byte address.
- `i_mem_req_wr_data` in `WORD_W` (32): write data, right-justified (byte 0 = bits 7:0).
- `i_mem_req_wr_en` in 1: 1 = write, 0 = read.
- `i_mem_req_count` in `MEM_COUNT_W` (2): 0 = no access, 1 = byte, 2 = half, 3 = word (n = 1/2/4 bytes).
- `o_mem_res_rd_data` out `WORD_W`: read data, right-justified, zero-extended; 0 for writes and errors.
- `o_mem_res_code` out `MEM_CODE_W` (2): `MEM_CODE_OK`=0, `MEM_CODE_MISALIGNED`=1, `MEM_CODE_OUT_OF_RANGE`=2.
- `o_mem_res_valid` out 1: one-cycle pulse per completed request.
- `o_busy` out 1: high while the second beat of a split access is pending.

## Operation
- Offset o = `addr[1:0]`, word w = `addr>>2`. An access crosses a boundary when o+n > 4. Examples: half at o=3; word at o≠0. A half at o=1 does not cross.
- A request is accepted on a rising edge when `o_busy`=0 and count≠0. Count=0 is ignored: no response, no write.
- Range check at acceptance: w ≥ DEPTH, or a crossing access with w+1 ≥ DEPTH, gives `MEM_CODE_OUT_OF_RANGE`, rd_data 0, and no bytes written. There are no partial writes.
- Crossing access with `ALLOW_SPLIT`=0: `MEM_CODE_MISALIGNED`, rd_data 0, no write.
- Non-crossing access: bytes o..o+n-1 of word w. On a write, byte k of wr_data goes to byte o+k and other lanes are unchanged. On a read, result byte k = word byte o+k, and the upper bytes are 0.
- Split access, FSM `IDLE` -> `SPLIT2` -> `IDLE`:
  - Beat 1, at the accept edge: bytes o..3 of word w. Read bytes are captured into a holding register.
  - Beat 2, at the next edge in `SPLIT2`: bytes 0..o+n-5 of word w+1. The address, data, count and wr_en used are the ones captured at acceptance.
  - Request inputs are ignored while in `SPLIT2`.
  - Result byte k = byte o+k of the concatenation {word w+1, word w}.
- Array contents are not affected by reset. They are undefined until written.
- Write responses: code OK, rd_data 0.

## Timing
- Reset (async assert): `o_mem_res_rd_data`=0, `o_mem_res_code`=0, `o_mem_res_valid`=0, `o_busy`=0, FSM=`IDLE`.
- Reset deassertion is synchronised by the integrator. The first acceptable edge is the first edge with `aresetn`=1.
- Non-crossing access and any error: accepted at edge E0. Response outputs update at E0; `o_mem_res_valid`=1 for the cycle after E0. Latency is 1.
- Split access: accepted at E0. `o_busy`=1 for the cycle E0–E1. Response updates at E1; `o_mem_res_valid`=1 for the cycle E1–E2. Latency is 2. A new request can be accepted at E2.
- Write at edge E followed by a read at edge E+1 of the same bytes returns the new data.
- `o_mem_res_rd_data` and `o_mem_res_code` hold their values until the next response.
- Reset asserted while in `SPLIT2`: beat 2 is abandoned. The beat-1 write, already committed, remains. No response is issued.

## Test plan
- Write word 0xDEADBEEF at addr 0x10, then read word at 0x10 -> valid 1 cycle after the read edge, data 0xDEADBEEF, code 0.
- Write byte 0x5A at 0x11, then read word 0x10 -> 0xDEAD5AEF. Read half at 0x12 -> 0x0000DEAD.
- `ALLOW_SPLIT`=1: word 0x44332211 already at 0x20 and 0x88776655 at 0x24; read word at 0x23 -> `o_busy` high 1 cycle, then data 0x77665544 at latency 2. Write half 0xBEEF at 0x27 -> byte 0x27=0xEF, byte 0x28=0xBE.
- `ALLOW_SPLIT`=0: read half at 0x23 -> code 1, data 0, latency 1. Write word at 0x21 leaves 0x20/0x24 unchanged.
- Word read at addr DEPTH*4 -> code 2, data 0. With DEPTH=1024, split word write at 0xFFD -> code 2, no byte of word 1023 changed.
- Assert `aresetn` low during `SPLIT2` of a split write -> all outputs 0 immediately, no valid pulse, beat-1 bytes written and beat-2 bytes unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane word array serving single-cycle EX-stage requests.
// Word-boundary-crossing accesses either run as two beats (IDLE -> SPLIT2) or are rejected.
module dmem_responder #(
   parameter int DEPTH       = 1024,
   parameter bit ALLOW_SPLIT = 1'b1,
   parameter int ADDR_W      = 32,
   parameter int WORD_W      = 32,
   parameter int MEM_COUNT_W = 2,
   parameter int MEM_CODE_W  = 2
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic [ADDR_W-1:0]      i_mem_req_addr,
   input  logic [WORD_W-1:0]      i_mem_req_wr_data,
   input  logic                   i_mem_req_wr_en,
   input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
   output logic [WORD_W-1:0]      o_mem_res_rd_data,
   output logic [MEM_CODE_W-1:0]  o_mem_res_code,
   output logic                   o_mem_res_valid,
   output logic                   o_busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-3:0] DEPTH_WI = (ADDR_W-2)'(DEPTH);
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK           = MEM_CODE_W'(0);
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED   = MEM_CODE_W'(1);
   localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_RANGE = MEM_CODE_W'(2);

   typedef enum logic {
      IDLE   = 1'b0,
      SPLIT2 = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [WORD_W-1:0]     rd_data_q, rd_data_d;
   logic [MEM_CODE_W-1:0] code_q, code_d;
   logic                  valid_q, valid_d;

   // Context captured at acceptance of a split access, consumed by beat 2.
   logic [WORD_W-1:0] hold_q, hold_d;
   logic [1:0]        off_q, off_d;
   logic [WORD_W-1:0] size_mask_q, size_mask_d;
   logic [3:0]        be_hi_q, be_hi_d;
   logic [WORD_W-1:0] wdata_hi_q, wdata_hi_d;
   logic              wr_en_q, wr_en_d;
   logic [IDX_W-1:0]  widx_hi_q, widx_hi_d;

   logic [1:0]          req_off;
   logic [ADDR_W-3:0]   req_word, req_word_inc;
   logic [2:0]          req_nbytes;
   logic [7:0]          lane_base, lane_mask8;
   logic [WORD_W-1:0]   size_mask;
   logic [2*WORD_W-1:0] wr_wide;
   logic                req_cross, out_of_range, accept;

   logic [IDX_W-1:0]    mem_idx;
   logic [WORD_W-1:0]   mem_rd_word;
   logic                mem_we;
   logic [3:0]          mem_be;
   logic [WORD_W-1:0]   mem_wdata;
   logic [2*WORD_W-1:0] rd_cat;
   logic [WORD_W-1:0]   rd_shift;

   // Request decode: lane mask spans 8 lanes so bits 7:4 are the second-word lanes.
   always_comb begin
      req_off      = i_mem_req_addr[1:0];
      req_word     = i_mem_req_addr[ADDR_W-1:2];
      req_word_inc = req_word + 1'b1;
      req_nbytes   = 3'd0;
      lane_base    = 8'h00;
      size_mask    = '0;
      case (i_mem_req_count)
         2'd1: begin
            req_nbytes = 3'd1;
            lane_base  = 8'h01;
            size_mask  = {{(WORD_W-8){1'b0}}, 8'hFF};
         end
         2'd2: begin
            req_nbytes = 3'd2;
            lane_base  = 8'h03;
            size_mask  = {{(WORD_W-16){1'b0}}, 16'hFFFF};
         end
         2'd3: begin
            req_nbytes = 3'd4;
            lane_base  = 8'h0F;
            size_mask  = '1;
         end
         default: ;
      endcase
      req_cross    = ({1'b0, req_off} + req_nbytes) > 3'd4;
      lane_mask8   = lane_base << req_off;
      wr_wide      = {{WORD_W{1'b0}}, i_mem_req_wr_data} << {req_off, 3'b000};
      out_of_range = (req_word >= DEPTH_WI) || (req_cross && (req_word_inc >= DEPTH_WI));
      accept       = aresetn && (state_q == IDLE) && (i_mem_req_count != '0);
   end

   assign mem_idx = (state_q == SPLIT2) ? widx_hi_q : req_word[IDX_W-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         always_ff @(posedge clk) begin
            if (mem_we && mem_be[gi]) begin
               lane_mem[mem_idx] <= mem_wdata[gi*8 +: 8];
            end
         end
         assign mem_rd_word[gi*8 +: 8] = lane_mem[mem_idx];
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      rd_data_d   = rd_data_q;
      code_d      = code_q;
      valid_d     = 1'b0;
      hold_d      = hold_q;
      off_d       = off_q;
      size_mask_d = size_mask_q;
      be_hi_d     = be_hi_q;
      wdata_hi_d  = wdata_hi_q;
      wr_en_d     = wr_en_q;
      widx_hi_d   = widx_hi_q;
      mem_we      = 1'b0;
      mem_be      = 4'h0;
      mem_wdata   = '0;
      rd_cat      = '0;
      rd_shift    = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (out_of_range) begin
                  valid_d   = 1'b1;
                  code_d    = MEM_CODE_OUT_OF_RANGE;
                  rd_data_d = '0;
               end else if (req_cross && !ALLOW_SPLIT) begin
                  valid_d   = 1'b1;
                  code_d    = MEM_CODE_MISALIGNED;
                  rd_data_d = '0;
               end else begin
                  mem_we    = i_mem_req_wr_en;
                  mem_be    = lane_mask8[3:0];
                  mem_wdata = wr_wide[WORD_W-1:0];
                  if (req_cross) begin
                     // Beat 1 done now; keep the low word so beat 2 can assemble the result.
                     hold_d      = mem_rd_word;
                     off_d       = req_off;
                     size_mask_d = size_mask;
                     be_hi_d     = lane_mask8[7:4];
                     wdata_hi_d  = wr_wide[2*WORD_W-1:WORD_W];
                     wr_en_d     = i_mem_req_wr_en;
                     widx_hi_d   = req_word_inc[IDX_W-1:0];
                     state_d     = SPLIT2;
                  end else begin
                     rd_cat    = {{WORD_W{1'b0}}, mem_rd_word};
                     rd_shift  = WORD_W'(rd_cat >> {req_off, 3'b000});
                     valid_d   = 1'b1;
                     code_d    = MEM_CODE_OK;
                     rd_data_d = i_mem_req_wr_en ? '0 : (rd_shift & size_mask);
                  end
               end
            end
         end
         SPLIT2: begin
            mem_we    = wr_en_q;
            mem_be    = be_hi_q;
            mem_wdata = wdata_hi_q;
            rd_cat    = {mem_rd_word, hold_q};
            rd_shift  = WORD_W'(rd_cat >> {off_q, 3'b000});
            valid_d   = 1'b1;
            code_d    = MEM_CODE_OK;
            rd_data_d = wr_en_q ? '0 : (rd_shift & size_mask_q);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         rd_data_q   <= '0;
         code_q      <= '0;
         valid_q     <= 1'b0;
         hold_q      <= '0;
         off_q       <= '0;
         size_mask_q <= '0;
         be_hi_q     <= '0;
         wdata_hi_q  <= '0;
         wr_en_q     <= 1'b0;
         widx_hi_q   <= '0;
      end else begin
         state_q     <= state_d;
         rd_data_q   <= rd_data_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         hold_q      <= hold_d;
         off_q       <= off_d;
         size_mask_q <= size_mask_d;
         be_hi_q     <= be_hi_d;
         wdata_hi_q  <= wdata_hi_d;
         wr_en_q     <= wr_en_d;
         widx_hi_q   <= widx_hi_d;
      end
   end

   assign o_mem_res_rd_data = rd_data_q;
   assign o_mem_res_code    = code_q;
   assign o_mem_res_valid   = valid_q;
   assign o_busy            = (state_q == SPLIT2);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (split allowed / rejected), table-driven requests
// with a scoreboard queue, plus hand sequences for busy, back-to-back and reset-in-SPLIT2.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic aresetn;
   always #5 clk = ~clk;

   logic [31:0] s_addr, s_wd, n_addr, n_wd;
   logic        s_we, n_we;
   logic [1:0]  s_cnt, n_cnt;
   logic [31:0] data_s, data_n;
   logic [1:0]  code_s, code_n;
   logic        valid_s, valid_n, busy_s, busy_n;

   dmem_responder #(.DEPTH(1024), .ALLOW_SPLIT(1'b1)) dut_s (
      .clk(clk), .aresetn(aresetn),
      .i_mem_req_addr(s_addr), .i_mem_req_wr_data(s_wd),
      .i_mem_req_wr_en(s_we), .i_mem_req_count(s_cnt),
      .o_mem_res_rd_data(data_s), .o_mem_res_code(code_s),
      .o_mem_res_valid(valid_s), .o_busy(busy_s)
   );

   dmem_responder #(.DEPTH(1024), .ALLOW_SPLIT(1'b0)) dut_n (
      .clk(clk), .aresetn(aresetn),
      .i_mem_req_addr(n_addr), .i_mem_req_wr_data(n_wd),
      .i_mem_req_wr_en(n_we), .i_mem_req_count(n_cnt),
      .o_mem_res_rd_data(data_n), .o_mem_res_code(code_n),
      .o_mem_res_valid(valid_n), .o_busy(busy_n)
   );

   typedef struct {
      bit          sel;   // 0 = split instance, 1 = no-split instance
      bit          we;
      logic [31:0] addr;
      logic [1:0]  cnt;
      logic [31:0] wd;
      logic [1:0]  code;
      logic [31:0] data;
      int          lat;   // 0 = no response expected
   } vec_t;

   typedef struct {
      bit          sel;
      logic [1:0]  code;
      logic [31:0] data;
      int          lat;
      int          issue;
      int          tag;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void add(input bit sel, input bit we, input logic [31:0] addr,
                               input logic [1:0] cnt, input logic [31:0] wd,
                               input logic [1:0] code, input logic [31:0] data, input int lat);
      vec_t v;
      v.sel = sel; v.we = we; v.addr = addr; v.cnt = cnt; v.wd = wd;
      v.code = code; v.data = data; v.lat = lat;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input bit sel, input logic [1:0] code, input logic [31:0] data,
                           input int lat, input int tag);
      exp_t e;
      e.sel = sel; e.code = code; e.data = data; e.lat = lat; e.issue = cyc; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic score(input bit sel, input logic [1:0] code, input logic [31:0] data);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL spurious_valid dut%0d: got code %0d data %h, want no response", sel, code, data);
      end else begin
         e = sb.pop_front();
         if (e.sel != sel || e.code !== code || e.data !== data || (cyc - e.issue) != e.lat) begin
            n_bad++;
            $display("FAIL resp_%0d: got dut%0d code %0d data %h lat %0d, want dut%0d code %0d data %h lat %0d",
                     e.tag, sel, code, data, cyc - e.issue, e.sel, e.code, e.data, e.lat);
         end else begin
            $display("txn %0d dut%0d: code %0d data %h lat %0d", e.tag, sel, code, data, cyc - e.issue);
         end
      end
   endtask

   always @(negedge clk) begin
      if (valid_s === 1'b1) score(1'b0, code_s, data_s);
      if (valid_n === 1'b1) score(1'b1, code_n, data_n);
   end

   task automatic drive(input bit sel, input bit we, input logic [31:0] addr,
                        input logic [1:0] cnt, input logic [31:0] wd);
      if (!sel) begin
         s_we = we; s_addr = addr; s_cnt = cnt; s_wd = wd;
      end else begin
         n_we = we; n_addr = addr; n_cnt = cnt; n_wd = wd;
      end
   endtask

   task automatic idle_inputs();
      s_cnt = 2'd0; s_we = 1'b0;
      n_cnt = 2'd0; n_we = 1'b0;
   endtask

   task automatic wait_drain(input int tag);
      #1;
      for (int k = 0; k < 8; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout_%0d: got %0d responses outstanding, want 0", tag, sb.size());
         sb.delete();
      end
   endtask

   task automatic run_vec(input vec_t v, input int tag);
      @(negedge clk);
      drive(v.sel, v.we, v.addr, v.cnt, v.wd);
      if (v.lat != 0) push_exp(v.sel, v.code, v.data, v.lat, tag);
      else $display("txn %0d dut%0d: count 0 request, no response expected", tag, v.sel);
      @(negedge clk);
      idle_inputs();
      if (v.lat == 0) repeat (2) @(negedge clk);
      wait_drain(tag);
   endtask

   task automatic run_one(input bit sel, input bit we, input logic [31:0] addr,
                          input logic [1:0] cnt, input logic [31:0] wd,
                          input logic [1:0] code, input logic [31:0] data, input int lat,
                          input int tag);
      vec_t v;
      v.sel = sel; v.we = we; v.addr = addr; v.cnt = cnt; v.wd = wd;
      v.code = code; v.data = data; v.lat = lat;
      run_vec(v, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      s_addr = '0; s_wd = '0; n_addr = '0; n_wd = '0;
      idle_inputs();
      aresetn = 1'b1;
      #2 aresetn = 1'b0;
      #1;
      // Before any clock edge: reset must act asynchronously.
      check("rst_data_s",  data_s, 32'h0);
      check("rst_code_s",  {30'b0, code_s}, 32'h0);
      check("rst_valid_s", {31'b0, valid_s}, 32'h0);
      check("rst_busy_s",  {31'b0, busy_s}, 32'h0);
      check("rst_data_n",  data_n, 32'h0);
      check("rst_code_n",  {30'b0, code_n}, 32'h0);
      check("rst_valid_n", {31'b0, valid_n}, 32'h0);
      check("rst_busy_n",  {31'b0, busy_n}, 32'h0);
      repeat (3) @(negedge clk);
      aresetn = 1'b1;

      //   sel we  addr          cnt  wdata         code  data          lat
      add(0, 1, 32'h0000_0010, 2'd3, 32'hDEADBEEF, 2'd0, 32'h0,        1);
      add(0, 0, 32'h0000_0010, 2'd3, 32'h0,        2'd0, 32'hDEADBEEF, 1);
      add(0, 1, 32'h0000_0011, 2'd1, 32'hFFFFFF5A, 2'd0, 32'h0,        1);
      add(0, 0, 32'h0000_0010, 2'd3, 32'h0,        2'd0, 32'hDEAD5AEF, 1);
      add(0, 1, 32'h0000_0010, 2'd0, 32'hFFFFFFFF, 2'd0, 32'h0,        0);
      add(0, 0, 32'h0000_0010, 2'd3, 32'h0,        2'd0, 32'hDEAD5AEF, 1);
      add(0, 0, 32'h0000_0012, 2'd2, 32'h0,        2'd0, 32'h0000DEAD, 1);
      add(0, 0, 32'h0000_0013, 2'd1, 32'h0,        2'd0, 32'h000000DE, 1);
      add(0, 0, 32'h0000_0011, 2'd2, 32'h0,        2'd0, 32'h0000AD5A, 1);
      add(0, 1, 32'h0000_0020, 2'd3, 32'h44332211, 2'd0, 32'h0,        1);
      add(0, 1, 32'h0000_0024, 2'd3, 32'h88776655, 2'd0, 32'h0,        1);
      add(0, 0, 32'h0000_0023, 2'd3, 32'h0,        2'd0, 32'h77665544, 2);
      add(0, 0, 32'h0000_0022, 2'd2, 32'h0,        2'd0, 32'h00004433, 1);
      add(0, 1, 32'h0000_0027, 2'd2, 32'h0000BEEF, 2'd0, 32'h0,        2);
      add(0, 0, 32'h0000_0027, 2'd1, 32'h0,        2'd0, 32'h000000EF, 1);
      add(0, 0, 32'h0000_0028, 2'd1, 32'h0,        2'd0, 32'h000000BE, 1);
      add(0, 0, 32'h0000_0024, 2'd3, 32'h0,        2'd0, 32'hEF776655, 1);
      add(0, 0, 32'h0000_0027, 2'd2, 32'h0,        2'd0, 32'h0000BEEF, 2);
      add(0, 0, 32'h0000_1000, 2'd3, 32'h0,        2'd2, 32'h0,        1);
      add(0, 0, 32'h0000_1001, 2'd1, 32'h0,        2'd2, 32'h0,        1);
      add(0, 1, 32'h0000_0FFC, 2'd3, 32'h11223344, 2'd0, 32'h0,        1);
      add(0, 1, 32'h0000_0FFD, 2'd3, 32'hAABBCCDD, 2'd2, 32'h0,        1);
      add(0, 1, 32'h0000_0FFF, 2'd2, 32'h00009999, 2'd2, 32'h0,        1);
      add(0, 0, 32'h0000_0FFC, 2'd3, 32'h0,        2'd0, 32'h11223344, 1);
      add(0, 0, 32'h0000_0FFE, 2'd2, 32'h0,        2'd0, 32'h00001122, 1);
      add(1, 1, 32'h0000_0020, 2'd3, 32'h44332211, 2'd0, 32'h0,        1);
      add(1, 1, 32'h0000_0024, 2'd3, 32'h88776655, 2'd0, 32'h0,        1);
      add(1, 0, 32'h0000_0023, 2'd2, 32'h0,        2'd1, 32'h0,        1);
      add(1, 1, 32'h0000_0021, 2'd3, 32'hCAFEF00D, 2'd1, 32'h0,        1);
      add(1, 0, 32'h0000_0020, 2'd3, 32'h0,        2'd0, 32'h44332211, 1);
      add(1, 0, 32'h0000_0024, 2'd3, 32'h0,        2'd0, 32'h88776655, 1);
      add(1, 0, 32'h0000_0021, 2'd2, 32'h0,        2'd0, 32'h00003322, 1);
      add(1, 0, 32'h0000_0023, 2'd1, 32'h0,        2'd0, 32'h00000044, 1);
      add(1, 0, 32'h0000_0022, 2'd2, 32'h0,        2'd0, 32'h00004433, 1);
      add(1, 0, 32'h0000_0FFD, 2'd3, 32'h0,        2'd2, 32'h0,        1);
      add(1, 0, 32'h0000_1000, 2'd1, 32'h0,        2'd2, 32'h0,        1);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Split read: busy for one cycle, input during SPLIT2 ignored, next request at E2.
      @(negedge clk);
      drive(0, 0, 32'h0000_0023, 2'd3, 32'h0);
      push_exp(0, 2'd0, 32'h77665544, 2, 100);
      @(negedge clk);
      check("busy_in_split2", {31'b0, busy_s}, 32'h1);
      drive(0, 1, 32'h0000_0010, 2'd1, 32'h000000FF);
      @(negedge clk);
      check("busy_after_split2", {31'b0, busy_s}, 32'h0);
      drive(0, 0, 32'h0000_0010, 2'd3, 32'h0);
      push_exp(0, 2'd0, 32'hDEAD5AEF, 1, 101);
      @(negedge clk);
      idle_inputs();
      wait_drain(101);

      // Reset during SPLIT2 of a split write: beat 1 stays, beat 2 abandoned.
      run_one(0, 1, 32'h0000_0030, 2'd3, 32'h03020100, 2'd0, 32'h0, 1, 102);
      run_one(0, 1, 32'h0000_0034, 2'd3, 32'h07060504, 2'd0, 32'h0, 1, 103);
      run_one(0, 0, 32'h0000_0010, 2'd3, 32'h0, 2'd0, 32'hDEAD5AEF, 1, 104);
      @(negedge clk);
      drive(0, 1, 32'h0000_0031, 2'd3, 32'hA1B2C3D4);
      $display("txn 105 dut0: split write at 0x31, reset during SPLIT2, no response expected");
      @(negedge clk);
      check("busy_before_reset", {31'b0, busy_s}, 32'h1);
      idle_inputs();
      aresetn = 1'b0;
      #1;
      check("midrst_data_s",  data_s, 32'h0);
      check("midrst_code_s",  {30'b0, code_s}, 32'h0);
      check("midrst_valid_s", {31'b0, valid_s}, 32'h0);
      check("midrst_busy_s",  {31'b0, busy_s}, 32'h0);
      @(negedge clk);
      aresetn = 1'b1;
      repeat (3) @(negedge clk);
      run_one(0, 0, 32'h0000_0030, 2'd3, 32'h0, 2'd0, 32'hB2C3D400, 1, 106);
      run_one(0, 0, 32'h0000_0034, 2'd3, 32'h0, 2'd0, 32'h07060504, 1, 107);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
